regfile_wb_queue: RTL and testbench

- Write-side initiator for the 32x32 register file.
- Accepts writeback requests from the execute/memory stage over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains one entry per cycle onto the register file write port (D_En/D_Addr/D).
- Supplies forwarded S/T read data so that writes still queued are visible to readers.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/wb_fwd_match.sv | 38 +++
 rtl/regfile_wb_queue.sv | 115 +++++++++++
 tb/tb_regfile_wb_queue.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback queue entry type.
// Used by regfile_wb_queue and wb_fwd_match.
package regfile_pkg;

   localparam int XLEN     = 32;
   localparam int AW       = 5;
   localparam int ZERO_REG = 0;
   localparam int NUM_REGS = 32;

   typedef struct packed {
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match lookup across the occupied writeback queue entries.
// Walks the entries from oldest (i_head) to youngest so the last hit wins.
module wb_fwd_match
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
)(
   input  wb_entry_t [DEPTH-1:0] i_entries,
   input  logic [DEPTH-1:0]      i_occ,
   input  logic [PW-1:0]         i_head,
   input  logic [AW-1:0]         i_addr,
   input  logic [XLEN-1:0]       i_fallback,
   output logic                  o_hit,
   output logic [XLEN-1:0]       o_data
);

   logic [PW-1:0] w_idx;

   always_comb begin
      o_hit  = 1'b0;
      o_data = i_fallback;
      w_idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = i_head + PW'(k);
         if (i_occ[w_idx] && (i_entries[w_idx].addr == i_addr)) begin
            o_hit  = 1'b1;
            o_data = i_entries[w_idx].data;
         end
      end
      // Register zero is hardwired; it never matches and always reads as zero.
      if (i_addr == AW'(ZERO_REG)) begin
         o_hit  = 1'b0;
         o_data = '0;
      end
   end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue feeding the register file write port, with S/T read forwarding.
// Macro REGFILE_WB_BYPASS_EN enables forwarding; without it, wb_ready stalls on pending S/T hazards.
module regfile_wb_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = regfile_pkg::XLEN,
   parameter int AW    = regfile_pkg::AW
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wb_valid,
   output logic                   wb_ready,
   input  logic [AW-1:0]          wb_addr,
   input  logic [XLEN-1:0]        wb_data,
   input  logic                   rf_hold,
   output logic                   D_En,
   output logic [AW-1:0]          D_Addr,
   output logic [XLEN-1:0]        D,
   input  logic [AW-1:0]          S_Addr,
   input  logic [AW-1:0]          T_Addr,
   input  logic [XLEN-1:0]        S_rf,
   input  logic [XLEN-1:0]        T_rf,
   output logic [XLEN-1:0]        S_fwd,
   output logic [XLEN-1:0]        T_fwd,
   output logic [$clog2(DEPTH):0] pending
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

`ifdef REGFILE_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   regfile_pkg::wb_entry_t [DEPTH-1:0] r_entries;
   logic [DEPTH-1:0]                   r_valid;
   logic [PW-1:0]                      r_head;
   logic [PW-1:0]                      r_tail;
   logic [CW-1:0]                      r_count;
   logic                               r_run;

   logic            w_full;
   logic            w_push;
   logic            w_pop;
   logic            w_s_hit;
   logic            w_t_hit;
   logic [XLEN-1:0] w_s_data;
   logic [XLEN-1:0] w_t_data;

   assign w_full  = (r_count == CW'(DEPTH));
   // Without forwarding the producer must not run ahead of a queued write it will read back.
   assign wb_ready = r_run & ~w_full & (BYPASS | ~(w_s_hit | w_t_hit));
   assign w_push  = wb_valid & wb_ready & (wb_addr != AW'(regfile_pkg::ZERO_REG));
   assign D_En    = (r_count != '0) & ~rf_hold;
   assign w_pop   = D_En;

   // Vacated slots are cleared, so an empty head reads as zero straight from the registers.
   assign D_Addr  = r_entries[r_head].addr;
   assign D       = r_entries[r_head].data;
   assign pending = r_count;

   assign S_fwd = BYPASS ? w_s_data : S_rf;
   assign T_fwd = BYPASS ? w_t_data : T_rf;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_entries <= '0;
         r_valid   <= '0;
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_run     <= 1'b0;
      end else begin
         r_run <= 1'b1;
         if (w_pop) begin
            r_entries[r_head] <= '0;
            r_valid[r_head]   <= 1'b0;
            r_head            <= r_head + 1'b1;
         end
         if (w_push) begin
            r_entries[r_tail].addr <= wb_addr;
            r_entries[r_tail].data <= wb_data;
            r_valid[r_tail]        <= 1'b1;
            r_tail                 <= r_tail + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   wb_fwd_match #(.DEPTH(DEPTH)) u_s_match (
      .i_entries  (r_entries),
      .i_occ      (r_valid),
      .i_head     (r_head),
      .i_addr     (S_Addr),
      .i_fallback (S_rf),
      .o_hit      (w_s_hit),
      .o_data     (w_s_data)
   );

   wb_fwd_match #(.DEPTH(DEPTH)) u_t_match (
      .i_entries  (r_entries),
      .i_occ      (r_valid),
      .i_head     (r_head),
      .i_addr     (T_Addr),
      .i_fallback (T_rf),
      .o_hit      (w_t_hit),
      .o_data     (w_t_data)
   );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: vector table, directed wrap/reset sequences, and random traffic
// against a queue-based reference model. Expectations follow REGFILE_WB_BYPASS_EN when defined.
module tb_regfile_wb_queue;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
   localparam int AW    = 5;

`ifdef REGFILE_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   wb_valid;
   logic                   wb_ready;
   logic [AW-1:0]          wb_addr;
   logic [XLEN-1:0]        wb_data;
   logic                   rf_hold;
   logic                   D_En;
   logic [AW-1:0]          D_Addr;
   logic [XLEN-1:0]        D;
   logic [AW-1:0]          S_Addr;
   logic [AW-1:0]          T_Addr;
   logic [XLEN-1:0]        S_rf;
   logic [XLEN-1:0]        T_rf;
   logic [XLEN-1:0]        S_fwd;
   logic [XLEN-1:0]        T_fwd;
   logic [$clog2(DEPTH):0] pending;

   int total = 0;
   int bad   = 0;

   regfile_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
      .clk      (clk),
      .reset    (reset),
      .wb_valid (wb_valid),
      .wb_ready (wb_ready),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .rf_hold  (rf_hold),
      .D_En     (D_En),
      .D_Addr   (D_Addr),
      .D        (D),
      .S_Addr   (S_Addr),
      .T_Addr   (T_Addr),
      .S_rf     (S_rf),
      .T_rf     (T_rf),
      .S_fwd    (S_fwd),
      .T_fwd    (T_fwd),
      .pending  (pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] v, a, d, h, sa, ta, srf, trf;
      logic [31:0] den, da, dd, pend, rdy, sf, tf;
   } vec_t;

   vec_t tbl[$];

   // Reference model: the queue contents in arrival order, oldest first.
   logic [31:0] mq_a[$];
   logic [31:0] mq_d[$];
   bit          m_alive;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] v, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] h, input logic [31:0] sa, input logic [31:0] ta,
                        input logic [31:0] srf, input logic [31:0] trf);
      wb_valid = v[0];
      wb_addr  = a[AW-1:0];
      wb_data  = d;
      rf_hold  = h[0];
      S_Addr   = sa[AW-1:0];
      T_Addr   = ta[AW-1:0];
      S_rf     = srf;
      T_rf     = trf;
   endtask

   function automatic vec_t mk(input logic [31:0] v, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] h, input logic [31:0] sa, input logic [31:0] ta,
                               input logic [31:0] srf, input logic [31:0] trf,
                               input logic [31:0] den, input logic [31:0] da, input logic [31:0] dd,
                               input logic [31:0] pend, input logic [31:0] rdy,
                               input logic [31:0] sf, input logic [31:0] tf);
      vec_t r;
      r.v = v; r.a = a; r.d = d; r.h = h; r.sa = sa; r.ta = ta; r.srf = srf; r.trf = trf;
      r.den = den; r.da = da; r.dd = dd; r.pend = pend; r.rdy = rdy; r.sf = sf; r.tf = tf;
      return r;
   endfunction

   function automatic bit m_has(input logic [31:0] a);
      if (a == 0) return 1'b0;
      foreach (mq_a[i]) if (mq_a[i] == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_fwd(input logic [31:0] a, input logic [31:0] rf);
      if (!BYP) return rf;
      if (a == 0) return 32'h0;
      for (int i = mq_a.size() - 1; i >= 0; i--) if (mq_a[i] == a) return mq_d[i];
      return rf;
   endfunction

   // One clock cycle checked against the model; entered and left at posedge+1.
   task automatic cyc(input logic [31:0] v, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] h, input logic [31:0] sa, input logic [31:0] ta,
                      input logic [31:0] srf, input logic [31:0] trf);
      bit e_den;
      bit e_rdy;
      drive(v, a, d, h, sa, ta, srf, trf);
      e_den = (mq_a.size() != 0) && !h[0];
      e_rdy = m_alive && (mq_a.size() != DEPTH) && (BYP || !(m_has(sa) || m_has(ta)));
      #2;
      chk("m_den",   32'(D_En),     32'(e_den));
      chk("m_daddr", 32'(D_Addr),   (mq_a.size() != 0) ? mq_a[0] : 32'h0);
      chk("m_d",     D,             (mq_d.size() != 0) ? mq_d[0] : 32'h0);
      chk("m_pend",  32'(pending),  32'(mq_a.size()));
      chk("m_rdy",   32'(wb_ready), 32'(e_rdy));
      chk("m_sfwd",  S_fwd,         m_fwd(sa, srf));
      chk("m_tfwd",  T_fwd,         m_fwd(ta, trf));
      @(posedge clk);
      m_alive = 1'b1;
      if (e_den) begin
         void'(mq_a.pop_front());
         void'(mq_d.pop_front());
      end
      if (v[0] && e_rdy && (a[AW-1:0] != 0)) begin
         mq_a.push_back(32'(a[AW-1:0]));
         mq_d.push_back(d);
      end
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      // Columns: v a d h sa ta srf trf | den daddr d pend rdy sfwd tfwd
      tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 2,       0, 0, 0, 0, 1, BYP ? 0 : 1, BYP ? 0 : 2));
      tbl.push_back(mk(0, 0, 0, 0, 5, 9, 32'h10, 32'h20,        1, 5, 32'hDEADBEEF, 1, BYP, BYP ? 32'hDEADBEEF : 32'h10, 32'h20));
      tbl.push_back(mk(0, 0, 0, 0, 5, 9, 32'h10, 32'h20,        0, 0, 0, 0, 1, 32'h10, 32'h20));
      tbl.push_back(mk(1, 1, 32'h101, 1, 0, 0, 0, 0,            0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 2, 32'h102, 1, 0, 0, 0, 0,            0, 1, 32'h101, 1, 1, 0, 0));
      tbl.push_back(mk(1, 3, 32'h103, 1, 0, 0, 0, 0,            0, 1, 32'h101, 2, 1, 0, 0));
      tbl.push_back(mk(1, 4, 32'h104, 1, 0, 0, 0, 0,            0, 1, 32'h101, 3, 1, 0, 0));
      tbl.push_back(mk(1, 6, 32'h106, 1, 0, 0, 0, 0,            0, 1, 32'h101, 4, 0, 0, 0));
      tbl.push_back(mk(1, 6, 32'h106, 0, 0, 0, 0, 0,            1, 1, 32'h101, 4, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                  1, 2, 32'h102, 3, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                  1, 3, 32'h103, 2, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                  1, 4, 32'h104, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 7, 32'h11, 1, 0, 0, 0, 0,             0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 7, 32'h22, 1, 0, 0, 0, 0,             0, 7, 32'h11, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 7, 8, 32'h99, 32'h88,        0, 7, 32'h11, 2, BYP, BYP ? 32'h22 : 32'h99, 32'h88));
      tbl.push_back(mk(0, 0, 0, 0, 7, 8, 32'h99, 32'h88,        1, 7, 32'h11, 2, BYP, BYP ? 32'h22 : 32'h99, 32'h88));
      tbl.push_back(mk(0, 0, 0, 0, 7, 8, 32'h99, 32'h88,        1, 7, 32'h22, 1, BYP, BYP ? 32'h22 : 32'h99, 32'h88));
      tbl.push_back(mk(0, 0, 0, 0, 7, 8, 32'h99, 32'h88,        0, 0, 0, 0, 1, 32'h99, 32'h88));
      tbl.push_back(mk(1, 0, 32'hFFFF, 0, 0, 0, 32'h55, 32'h66, 0, 0, 0, 0, 1, BYP ? 0 : 32'h55, BYP ? 0 : 32'h66));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h55, 32'h66,        0, 0, 0, 0, 1, BYP ? 0 : 32'h55, BYP ? 0 : 32'h66));

      // Reset asserted with a request on the inputs.
      reset = 1'b1;
      drive(1, 3, 32'h1234, 0, 0, 0, 0, 0);
      #1 reset = 1'b0;
      #11;
      chk("rst_den",   32'(D_En),     32'h0);
      chk("rst_daddr", 32'(D_Addr),   32'h0);
      chk("rst_d",     D,             32'h0);
      chk("rst_rdy",   32'(wb_ready), 32'h0);
      chk("rst_pend",  32'(pending),  32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("rdy_after_rst", 32'(wb_ready), 32'h1);

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].h, tbl[i].sa, tbl[i].ta, tbl[i].srf, tbl[i].trf);
         #2;
         chk($sformatf("r%0d_den", i),   32'(D_En),     tbl[i].den);
         chk($sformatf("r%0d_daddr", i), 32'(D_Addr),   tbl[i].da);
         chk($sformatf("r%0d_d", i),     D,             tbl[i].dd);
         chk($sformatf("r%0d_pend", i),  32'(pending),  tbl[i].pend);
         chk($sformatf("r%0d_rdy", i),   32'(wb_ready), tbl[i].rdy);
         chk($sformatf("r%0d_sfwd", i),  S_fwd,         tbl[i].sf);
         chk($sformatf("r%0d_tfwd", i),  T_fwd,         tbl[i].tf);
         @(posedge clk); #1;
      end

      // Fill under hold, then drain while enqueueing so both pointers wrap.
      mq_a.delete(); mq_d.delete(); m_alive = 1'b1;
      for (int i = 0; i < DEPTH; i++) cyc(1, 10 + i, 32'hA0 + i, 1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++)     cyc(1, 20 + i, 32'hB0 + i, 0, 0, 0, 0, 0);
      repeat (5) cyc(0, 0, 0, 0, 0, 0, 0, 0);

      // Reset in the middle of a drain with three entries queued.
      for (int i = 0; i < 3; i++) cyc(1, 3 + i, 32'hC0 + i, 1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("mid_den_before", 32'(D_En), 32'h1);
      #1 reset = 1'b0;
      #1;
      chk("mid_den",   32'(D_En),     32'h0);
      chk("mid_pend",  32'(pending),  32'h0);
      chk("mid_daddr", 32'(D_Addr),   32'h0);
      chk("mid_d",     D,             32'h0);
      chk("mid_rdy",   32'(wb_ready), 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      mq_a.delete(); mq_d.delete(); m_alive = 1'b0;
      repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 0);

      // Random traffic over a small address space so hits are common.
      repeat (400) begin
         cyc($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
             ($urandom_range(0, 3) == 0) ? 1 : 0,
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
